// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, PPROT bit constants and
// the data-width legality check used by the apbmaster slice.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;

    function automatic bit apb_dw_legal(input int unsigned dw);
        return (dw == 8) || (dw == 16) || (dw == 32) || (dw == 64);
    endfunction

endpackage

// File: rtl/apbmaster_if.sv
// Request port plus APB bus of the apbmaster. The master modport is the
// initiator's view; the slave modport is the requester/completer side.
interface apbmaster_if #(
    parameter int C_APB_ADDR_WIDTH = 12,
    parameter int C_APB_DATA_WIDTH = 32
);
    logic                            i_valid;
    logic                            o_ready;
    logic [C_APB_ADDR_WIDTH-1:0]     i_addr;
    logic                            i_write;
    logic [C_APB_DATA_WIDTH-1:0]     i_wdata;
    logic [C_APB_DATA_WIDTH/8-1:0]   i_wstrb;
    logic [2:0]                      i_prot;
    logic                            o_rvalid;
    logic [C_APB_DATA_WIDTH-1:0]     o_rdata;
    logic                            o_err;

    logic                            PSEL;
    logic                            PENABLE;
    logic                            PWRITE;
    logic [C_APB_ADDR_WIDTH-1:0]     PADDR;
    logic [C_APB_DATA_WIDTH-1:0]     PWDATA;
    logic [C_APB_DATA_WIDTH/8-1:0]   PWSTRB;
    logic [2:0]                      PPROT;
    logic                            PREADY;
    logic                            PSLVERR;
    logic [C_APB_DATA_WIDTH-1:0]     PRDATA;

    modport master (
        input  i_valid, i_addr, i_write, i_wdata, i_wstrb, i_prot,
        output o_ready, o_rvalid, o_rdata, o_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWSTRB, PPROT,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        output i_valid, i_addr, i_write, i_wdata, i_wstrb, i_prot,
        input  o_ready, o_rvalid, o_rdata, o_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWSTRB, PPROT,
        output PREADY, PSLVERR, PRDATA
    );

endinterface

// File: rtl/apbmaster.sv
// Single-outstanding APB4 initiator: valid/ready request in, APB setup/access
// phases out, one registered response pulse per accepted request.
module apbmaster
    import apb_pkg::*;
#(
    parameter int C_APB_ADDR_WIDTH = 12,
    parameter int C_APB_DATA_WIDTH = 32,
    parameter int OPT_TIMEOUT      = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    apbmaster_if.master bus
);
    localparam int AW = C_APB_ADDR_WIDTH;
    localparam int DW = C_APB_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int TW = (OPT_TIMEOUT > 0) ? $clog2(OPT_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (OPT_TIMEOUT > 0) ? TW'(OPT_TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] TO_MAX  = (OPT_TIMEOUT > 0) ? TW'(OPT_TIMEOUT) : '0;
    localparam bit DW_OK = apb_dw_legal(DW);

    apb_state_t state, state_nx;
    logic          ready, accept, complete, timeout_hit;
    logic [TW-1:0] tcnt;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pwstrb;
    logic [2:0]    pprot;
    logic          rvalid, err;
    logic [DW-1:0] rdata;

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        ready       = 1'b0;
        accept      = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.i_valid) begin
                    accept   = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: state_nx = ACCESS;
            ACCESS: begin
                if (bus.PREADY) begin
                    ready    = 1'b1;
                    complete = 1'b1;
                    if (bus.i_valid) begin
                        accept   = 1'b1;
                        state_nx = SETUP;
                    end else begin
                        state_nx = IDLE;
                    end
                // Fires on the Nth stalled ACCESS cycle, so the response lands
                // one cycle later together with PSEL dropping.
                end else if ((OPT_TIMEOUT > 0) && (tcnt == TO_LAST)) begin
                    timeout_hit = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pwstrb <= '0;
            pprot  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
            tcnt   <= '0;
        end else begin
            if (accept) begin
                paddr  <= bus.i_addr;
                pwrite <= bus.i_write;
                pwdata <= bus.i_wdata;
                pwstrb <= bus.i_write ? bus.i_wstrb : '0;
                pprot  <= bus.i_prot;
            end
            rvalid <= complete | timeout_hit;
            if (complete) begin
                err <= bus.PSLVERR;
                if (!pwrite) rdata <= bus.PRDATA;
            end else if (timeout_hit) begin
                err   <= 1'b1;
                rdata <= '0;
            end
            if (state == SETUP) begin
                tcnt <= '0;
            end else if ((state == ACCESS) && !bus.PREADY && (tcnt != TO_MAX)) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_rvalid = rvalid;
    assign bus.o_rdata  = rdata;
    assign bus.o_err    = err;
    assign bus.PSEL     = (state != IDLE);
    assign bus.PENABLE  = (state == ACCESS);
    assign bus.PWRITE   = pwrite;
    assign bus.PADDR    = paddr;
    assign bus.PWDATA   = pwdata;
    assign bus.PWSTRB   = pwstrb;
    assign bus.PPROT    = pprot;

    a_dw_legal: assert property (@(posedge PCLK) DW_OK);

    a_penable_psel: assert property (@(posedge PCLK) disable iff (PRESET)
        bus.PENABLE |-> bus.PSEL);

    a_access_stable: assert property (@(posedge PCLK) disable iff (PRESET)
        (state == ACCESS && !bus.PREADY && !timeout_hit) |=>
            (state == ACCESS) && $stable({bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PWSTRB, bus.PPROT}));

endmodule

// File: tb/tb_apbmaster.sv
// Directed self-checking bench for apbmaster (32-bit data, timeout of 4).
module tb_apbmaster;
    import apb_pkg::*;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apbmaster_if #(.C_APB_ADDR_WIDTH(12), .C_APB_DATA_WIDTH(32)) bus ();

    apbmaster #(
        .C_APB_ADDR_WIDTH(12),
        .C_APB_DATA_WIDTH(32),
        .OPT_TIMEOUT(4)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bus)
    );

    // Completer side: directed drive, or a zero-wait demo memory.
    logic        use_mem, tb_pready, tb_pslverr;
    logic [31:0] tb_prdata;
    logic [31:0] mem [0:15];

    assign bus.PREADY  = use_mem ? 1'b1 : tb_pready;
    assign bus.PSLVERR = use_mem ? 1'b0 : tb_pslverr;
    assign bus.PRDATA  = use_mem ? mem[bus.PADDR[5:2]] : tb_prdata;

    always @(posedge PCLK) begin
        if (use_mem && bus.PSEL && bus.PENABLE && bus.PWRITE) begin
            for (int b = 0; b < 4; b++)
                if (bus.PWSTRB[b]) mem[bus.PADDR[5:2]][8*b +: 8] <= bus.PWDATA[8*b +: 8];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic next_cycle();
        @(posedge PCLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic request(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot);
        bus.i_valid = 1'b1;
        bus.i_write = wr;
        bus.i_addr  = addr;
        bus.i_wdata = wdata;
        bus.i_wstrb = strb;
        bus.i_prot  = prot;
    endtask

    task automatic idle_req();
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        idle_req();
        request(1'b0, '0, '0, '0, '0);
        idle_req();
        use_mem = 1'b0; tb_pready = 1'b1; tb_pslverr = 1'b0; tb_prdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) next_cycle();
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000", {bus.PSEL, bus.PENABLE, bus.PWRITE});
        end
        checks++;
        if ({bus.PADDR, bus.PWDATA, bus.PWSTRB, bus.PPROT} !== 51'd0) begin
            failures++; $display("FAIL reset_fields got=%h exp=0", {bus.PADDR, bus.PWDATA, bus.PWSTRB, bus.PPROT});
        end
        checks++;
        if ({bus.o_rvalid, bus.o_err, bus.o_rdata} !== 34'd0) begin
            failures++; $display("FAIL reset_resp got=%h exp=0", {bus.o_rvalid, bus.o_err, bus.o_rdata});
        end
        checks++;
        if (bus.o_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready);
        end
        PRESET = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_write();
        tb_pready = 1'b1;
        request(1'b1, 12'h010, 32'h1234_5678, 4'hF, PPROT_NONSEC);
        settle();
        checks++;
        if (bus.o_ready !== 1'b1) begin
            failures++; $display("FAIL wr_t0_ready got=%b exp=1", bus.o_ready);
        end
        next_cycle(); idle_req(); settle();                        // t1
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.o_ready} !== 3'b100) begin
            failures++; $display("FAIL wr_t1_setup got=%b exp=100", {bus.PSEL, bus.PENABLE, bus.o_ready});
        end
        checks++;
        if ({bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PWSTRB, bus.PPROT} !== {12'h010, 1'b1, 32'h1234_5678, 4'hF, 3'b010}) begin
            failures++; $display("FAIL wr_t1_fields got=%h exp=%h",
                {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PWSTRB, bus.PPROT}, {12'h010, 1'b1, 32'h1234_5678, 4'hF, 3'b010});
        end
        next_cycle();                                             // t2
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.o_rvalid, bus.o_ready} !== 4'b1101) begin
            failures++; $display("FAIL wr_t2_access got=%b exp=1101", {bus.PSEL, bus.PENABLE, bus.o_rvalid, bus.o_ready});
        end
        next_cycle();                                             // t3
        checks++;
        if ({bus.o_rvalid, bus.o_err, bus.PSEL} !== 3'b100) begin
            failures++; $display("FAIL wr_t3_resp got=%b exp=100", {bus.o_rvalid, bus.o_err, bus.PSEL});
        end
        checks++;
        if (bus.o_rdata !== 32'h0) begin
            failures++; $display("FAIL wr_rdata_hold got=%h exp=00000000", bus.o_rdata);
        end
        next_cycle();                                             // t4
        checks++;
        if (bus.o_rvalid !== 1'b0) begin
            failures++; $display("FAIL wr_t4_pulse got=%b exp=0", bus.o_rvalid);
        end
    endtask

    task automatic test_read_wait();
        logic [53:0] snap;
        tb_pready = 1'b0;
        tb_prdata = 32'h8765_4321;
        request(1'b0, 12'h020, 32'hFFFF_FFFF, 4'hF, PPROT_PRIV | PPROT_INSTR);
        next_cycle(); idle_req();                                 // t1
        checks++;
        if ({bus.PWRITE, bus.PWSTRB, bus.PPROT} !== 8'b0_0000_101) begin
            failures++; $display("FAIL rd_t1_fields got=%b exp=00000101", {bus.PWRITE, bus.PWSTRB, bus.PPROT});
        end
        next_cycle();                                             // t2
        snap = {bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PWSTRB, bus.PPROT};
        checks++;
        if (snap[53:52] !== 2'b11 || snap[51:40] !== 12'h020) begin
            failures++; $display("FAIL rd_t2_access got=%h exp=psel/pen=3 addr=020", snap[53:40]);
        end
        for (int t = 3; t <= 4; t++) begin
            next_cycle();                                         // t3, t4
            checks++;
            if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PWSTRB, bus.PPROT} !== snap
                || {bus.o_rvalid, bus.o_ready} !== 2'b00) begin
                failures++; $display("FAIL rd_stable_t%0d got=%h exp=%h rv/rdy=%b", t,
                    {bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PWSTRB, bus.PPROT}, snap,
                    {bus.o_rvalid, bus.o_ready});
            end
        end
        tb_pready = 1'b1; settle();
        checks++;
        if (bus.o_ready !== 1'b1) begin
            failures++; $display("FAIL rd_t4_ready got=%b exp=1", bus.o_ready);
        end
        next_cycle();                                             // t5
        checks++;
        if ({bus.o_rvalid, bus.o_err, bus.PSEL, bus.o_rdata} !== {3'b100, 32'h8765_4321}) begin
            failures++; $display("FAIL rd_t5_resp got=%h exp=%h",
                {bus.o_rvalid, bus.o_err, bus.PSEL, bus.o_rdata}, {3'b100, 32'h8765_4321});
        end
    endtask

    task automatic test_error();
        tb_pready = 1'b1; tb_pslverr = 1'b1; tb_prdata = 32'hDEAD_BEEF;
        request(1'b0, 12'h030, '0, 4'hF, '0);
        next_cycle(); idle_req();
        next_cycle();
        next_cycle();                                             // t3
        checks++;
        if ({bus.o_rvalid, bus.o_err, bus.o_rdata} !== {2'b11, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL err_resp got=%h exp=%h", {bus.o_rvalid, bus.o_err, bus.o_rdata}, {2'b11, 32'hDEAD_BEEF});
        end
        tb_pslverr = 1'b0;
        request(1'b1, 12'h034, 32'h0BAD_F00D, 4'h3, '0);
        next_cycle(); idle_req();                                 // t4
        checks++;
        if ({bus.o_rvalid, bus.PSEL, bus.PENABLE} !== 3'b010) begin
            failures++; $display("FAIL err_pulse got=%b exp=010", {bus.o_rvalid, bus.PSEL, bus.PENABLE});
        end
        next_cycle();
        next_cycle();                                             // t6
        checks++;
        if ({bus.o_rvalid, bus.o_err, bus.o_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL err_next got=%h exp=%h", {bus.o_rvalid, bus.o_err, bus.o_rdata}, {2'b10, 32'hDEAD_BEEF});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pen;
        logic       psel_all;
        pen = '0; psel_all = 1'b1;
        use_mem = 1'b1;
        request(1'b1, 12'h004, 32'hA5A5_5A5A, 4'hF, '0);
        next_cycle();                                             // t1
        pen = {pen[2:0], bus.PENABLE}; psel_all &= bus.PSEL;
        request(1'b0, 12'h004, '0, 4'hF, '0);
        next_cycle();                                             // t2
        pen = {pen[2:0], bus.PENABLE}; psel_all &= bus.PSEL;
        next_cycle(); idle_req();                                 // t3
        pen = {pen[2:0], bus.PENABLE}; psel_all &= bus.PSEL;
        checks++;
        if ({bus.o_rvalid, bus.o_err, bus.PWRITE} !== 3'b100) begin
            failures++; $display("FAIL b2b_wr_resp got=%b exp=100", {bus.o_rvalid, bus.o_err, bus.PWRITE});
        end
        next_cycle();                                             // t4
        pen = {pen[2:0], bus.PENABLE}; psel_all &= bus.PSEL;
        checks++;
        if ({psel_all, pen} !== 5'b1_0101) begin
            failures++; $display("FAIL b2b_pattern got=%b exp=10101", {psel_all, pen});
        end
        next_cycle();                                             // t5
        checks++;
        if ({bus.o_rvalid, bus.o_err, bus.PSEL, bus.o_rdata} !== {3'b100, 32'hA5A5_5A5A}) begin
            failures++; $display("FAIL b2b_rd_resp got=%h exp=%h",
                {bus.o_rvalid, bus.o_err, bus.PSEL, bus.o_rdata}, {3'b100, 32'hA5A5_5A5A});
        end
        use_mem = 1'b0;
    endtask

    task automatic test_timeout();
        logic early;
        // PREADY arriving on the last allowed ACCESS cycle is a normal completion.
        tb_pready = 1'b0; tb_pslverr = 1'b0; tb_prdata = 32'h1357_9BDF;
        request(1'b0, 12'h044, '0, '0, '0);
        next_cycle(); idle_req();                                 // t1
        repeat (3) next_cycle();                                  // t2..t4
        next_cycle();                                             // t5
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.o_rvalid} !== 3'b110) begin
            failures++; $display("FAIL to_edge_access got=%b exp=110", {bus.PSEL, bus.PENABLE, bus.o_rvalid});
        end
        tb_pready = 1'b1;
        next_cycle();                                             // t6
        checks++;
        if ({bus.o_rvalid, bus.o_err, bus.o_rdata} !== {2'b10, 32'h1357_9BDF}) begin
            failures++; $display("FAIL to_edge_resp got=%h exp=%h", {bus.o_rvalid, bus.o_err, bus.o_rdata}, {2'b10, 32'h1357_9BDF});
        end
        tb_pready = 1'b0;
        request(1'b0, 12'h048, '0, '0, '0);
        next_cycle(); idle_req();                                 // t1
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();                                         // t2..t5
            if (bus.o_rvalid || !bus.PSEL || !bus.PENABLE || bus.o_ready) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            failures++; $display("FAIL to_wait got=early_exit exp=4_access_cycles");
        end
        next_cycle();                                             // t6
        checks++;
        if ({bus.o_rvalid, bus.o_err, bus.o_rdata} !== {2'b11, 32'h0}) begin
            failures++; $display("FAIL to_resp got=%h exp=%h", {bus.o_rvalid, bus.o_err, bus.o_rdata}, {2'b11, 32'h0});
        end
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.o_ready} !== 3'b001) begin
            failures++; $display("FAIL to_idle got=%b exp=001", {bus.PSEL, bus.PENABLE, bus.o_ready});
        end
        next_cycle();                                             // t7
        checks++;
        if ({bus.o_rvalid, bus.o_ready} !== 2'b01) begin
            failures++; $display("FAIL to_after got=%b exp=01", {bus.o_rvalid, bus.o_ready});
        end
    endtask

    task automatic test_reset_mid();
        logic stray;
        tb_pready = 1'b0;
        request(1'b1, 12'h050, 32'hCAFE_F00D, 4'h3, PPROT_NONSEC);
        next_cycle(); idle_req();                                 // t1
        next_cycle();                                             // t2
        next_cycle();                                             // t3
        PRESET = 1'b1; tb_pready = 1'b1;
        next_cycle();                                             // t4
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PWSTRB, bus.PPROT} !== 54'd0) begin
            failures++; $display("FAIL rstmid_apb got=%h exp=0",
                {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PWSTRB, bus.PPROT});
        end
        checks++;
        if ({bus.o_rvalid, bus.o_err, bus.o_ready} !== 3'b001) begin
            failures++; $display("FAIL rstmid_resp got=%b exp=001", {bus.o_rvalid, bus.o_err, bus.o_ready});
        end
        PRESET = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            next_cycle();
            if (bus.o_rvalid !== 1'b0 || bus.PSEL !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            failures++; $display("FAIL rstmid_stray got=response_or_psel exp=none");
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_error();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apbmaster.md
# apbmaster

Single-outstanding APB4 initiator. Converts a simple valid/ready request port into APB setup/access phases and returns one response per request. Sits between an internal bus bridge or CPU-side register port and any APB completer, such as the demonstration APB memory slave. Supports back-to-back transfers and an optional PREADY timeout.

## Interface
- C_APB_ADDR_WIDTH, 12: APB address width (AW)
- C_APB_DATA_WIDTH, 32: APB data width (DW), must be 8/16/32/64
- OPT_TIMEOUT, 0: max ACCESS cycles waiting for PREADY; 0 disables the timeout
- PCLK  in  1  sole clock, all logic posedge
- PRESET  in  1  synchronous, active-high reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready
- i_addr  in  AW  byte address
- i_write  in  1  1 = write, 0 = read
- i_wdata  in  DW  write data
- i_wstrb  in  DW/8  byte strobes, writes only
- i_prot  in  3  passed to PPROT
- o_rvalid  out  1  one-cycle response pulse, no backpressure
- o_rdata  out  DW  read data, valid with o_rvalid
- o_err  out  1  PSLVERR or timeout, valid with o_rvalid
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  AW;  PWDATA  out  DW;  PWSTRB  out  DW/8;  PPROT  out  3
- PREADY, PSLVERR  in  1 each;  PRDATA  in  DW

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: PSEL=0, PENABLE=0, o_ready=1. On accept, go to SETUP.
- On accept, register PADDR, PWRITE, PWDATA, PPROT and PWSTRB. PWSTRB = i_wstrb for writes and 0 for reads.
- SETUP: PSEL=1, PENABLE=0. Always go to ACCESS next cycle. o_ready=0.
- ACCESS: PSEL=1, PENABLE=1. All APB outputs are held stable until completion.
- Completion is PREADY=1 in ACCESS. Register o_rvalid=1 and o_err=PSLVERR.
  - Reads: o_rdata=PRDATA.
  - Writes: o_rdata holds its previous value.
- o_ready = (state==IDLE) || (state==ACCESS && PREADY). This path is combinational from PREADY.
- Accept during completing ACCESS: go straight to SETUP with new registered fields. PSEL stays 1 and PENABLE drops to 0.
- Completion with no new accept: go to IDLE.
- Timeout (OPT_TIMEOUT=N>0):
  - The counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - When the count reaches N, force completion: o_rvalid=1, o_err=1, o_rdata=0, PSEL/PENABLE drop, go to IDLE.
  - o_ready stays 0 in that cycle.
- Counter width is $clog2(OPT_TIMEOUT+1). The counter saturates and never wraps.
- PREADY and PSLVERR are ignored outside ACCESS.

## Timing
- Reset (PRESET=1 at a clock edge) forces:
  - state=IDLE.
  - PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, PWSTRB=0, PPROT=0.
  - o_rvalid=0, o_err=0, o_rdata=0, timeout counter=0.
- Reset mid-transfer abandons the transfer with no response pulse. PSEL is 0 on the next cycle.
- Latency: accept edge is t0. Then SETUP at t1, ACCESS at t2.
  - With PREADY=1 at t2, o_rvalid is high during t3.
  - Minimum request-to-response is 3 cycles.
  - Each PREADY=0 cycle adds one.
- Back-to-back throughput: one transfer per 2 cycles.
- o_rvalid is high for exactly one cycle per accepted request. It is never asserted without a prior accept.

## Structure
- Shared package (apb_pkg): state enum {IDLE, SETUP, ACCESS}; PPROT bit constants (privileged, non-secure, instruction); APB data-width legality check.
- No sub-module is needed; the FSM, field registers and timeout counter fit in one module.
- Formal build pairs the module with the team's APB master-side property checker (fapb_master). Additional assertions:
  - PENABLE implies PSEL.
  - APB outputs stay stable during ACCESS.

## Test plan
- Single write: addr 0x010, data 0x12345678, strb 0xF, PREADY tied 1.
  - Required: SETUP at t1, ACCESS at t2, o_rvalid=1 and o_err=0 at t3, PSEL=0 at t3.
- Read with 2 wait states: PRDATA=0x87654321 and PREADY at the third ACCESS cycle.
  - Required: o_rvalid at t5, o_rdata=0x87654321, APB outputs stable t2..t4.
- Back-to-back: i_valid held for write 0x004 then read 0x004 against the demo memory slave.
  - Required: PSEL continuous, PENABLE pattern 0,1,0,1, read returns the written value.
- Error: PSLVERR=1 with PREADY on a read.
  - Required: o_err=1 and o_rvalid=1 for one cycle; next request proceeds normally.
- Timeout: OPT_TIMEOUT=4, PREADY held 0.
  - Required: o_rvalid=1, o_err=1, o_rdata=0 after 4 ACCESS cycles; PSEL=0 next cycle; o_ready=1 the cycle after.
- Reset mid-ACCESS: assert PRESET during a wait state.
  - Required: all outputs at reset values the next cycle; no o_rvalid pulse.
